// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Purpose  : Pipeline control unit for the in-order core. Merges per-stage
//            stall requests with the ID/EXE load-use hazard and EXE-stage
//            branch redirects, and produces a hold and a bubble enable for
//            every pipeline register plus the PC write port. It also keeps a
//            sticky stall watchdog.
// Options  : define PIPE_CTRL_PERF_EN to build the cycle/stall/flush
//            performance counters; without it those outputs are tied to 0.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
  parameter int NSTAGE    = 5,
  parameter int EXE_IDX   = 2,
  parameter int AW        = 32,
  parameter int RAW       = 5,
  parameter int STALL_MAX = 64,
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [NSTAGE-1:0]    stall_req_i,
  input  logic                 ld_exe_i,
  input  logic                 exe_reg_we_i,
  input  logic [RAW-1:0]       exe_reg_waddr_i,
  input  logic                 id_re1_i,
  input  logic                 id_re2_i,
  input  logic [RAW-1:0]       id_raddr1_i,
  input  logic [RAW-1:0]       id_raddr2_i,
  input  logic                 redirect_i,
  input  logic [AW-1:0]        redirect_addr_i,
  output logic [NSTAGE-1:0]    stall_o,
  output logic [NSTAGE-1:0]    flush_o,
  output logic                 pc_we_o,
  output logic [AW-1:0]        new_pc_o,
  output logic                 stall_timeout_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] stall_cnt_o,
  output logic [CNT_WIDTH-1:0] flush_cnt_o
);

  // FSM encoding: RUN applies redirects directly, PEND holds one that arrived
  // while a stage at or beyond EXE was stalled.
  localparam logic [0:0] c_st_run  = 1'b0;
  localparam logic [0:0] c_st_pend = 1'b1;

  // Watchdog run counter saturates at STALL_MAX.
  localparam int                 c_run_w    = $clog2(STALL_MAX + 1);
  localparam logic [c_run_w-1:0] c_run_max  = c_run_w'(STALL_MAX);
  localparam logic [c_run_w-1:0] c_run_last = c_run_w'(STALL_MAX - 1);
  localparam logic [c_run_w-1:0] c_run_one  = c_run_w'(1);

  logic [0:0]          r_state;
  logic [0:0]          w_state_nxt;
  logic [AW-1:0]       r_pend_addr;
  logic [c_run_w-1:0]  r_run;
  logic                r_timeout;

  logic                w_lu;
  logic                w_src1_hit;
  logic                w_src2_hit;
  logic [NSTAGE-1:0]   w_req;
  logic [NSTAGE-1:0]   w_hold;
  logic [NSTAGE-1:0]   w_bub;
  logic [NSTAGE-1:0]   w_redir_flush;
  logic                w_blk;
  logic                w_go;
  logic [AW-1:0]       w_go_addr;
  logic                w_latch;
  logic [NSTAGE-1:0]   w_stall_eff;
  logic [NSTAGE-1:0]   w_flush_eff;

  // ---------------------------------------------------------------------
  // Hazard detection: a load in EXE whose destination is read by ID.
  // Register 0 is hard-wired zero and never creates a dependency.
  // ---------------------------------------------------------------------
  assign w_src1_hit = id_re1_i && (id_raddr1_i == exe_reg_waddr_i);
  assign w_src2_hit = id_re2_i && (id_raddr2_i == exe_reg_waddr_i);
  assign w_lu       = ld_exe_i && exe_reg_we_i && (exe_reg_waddr_i != '0)
                      && (w_src1_hit || w_src2_hit);

  // The hazard behaves exactly like a stall request from the IF/ID register.
  always_comb begin
    w_req    = stall_req_i;
    w_req[1] = stall_req_i[1] | w_lu;
  end

  // ---------------------------------------------------------------------
  // Hold mask: register j holds when any request at index >= j exists,
  // which is "all j <= highest requesting index". The bubble goes into the
  // first register that is not held, directly downstream of the stall.
  // ---------------------------------------------------------------------
  for (genvar j = 0; j < NSTAGE; j++) begin : g_hold
    assign w_hold[j] = |w_req[NSTAGE-1:j];
  end

  assign w_bub[0] = 1'b0;
  for (genvar j = 1; j < NSTAGE; j++) begin : g_bub
    assign w_bub[j] = w_hold[j-1] & ~w_hold[j];
  end

  // A taken branch kills everything fetched after it: registers 1..EXE_IDX.
  for (genvar j = 0; j < NSTAGE; j++) begin : g_redir
    assign w_redir_flush[j] = (j >= 1) && (j <= EXE_IDX);
  end

  // A stall at or beyond the EXE register freezes the branch itself, so the
  // redirect cannot be taken yet.
  assign w_blk = w_hold[EXE_IDX];

  // FSM state register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state <= c_st_run;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // FSM next-state: park a blocked redirect, release it once unblocked.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      c_st_run:  if (redirect_i && w_blk) w_state_nxt = c_st_pend;
      c_st_pend: if (!w_blk)              w_state_nxt = c_st_run;
      default:                            w_state_nxt = c_st_run;
    endcase
  end

  // FSM outputs: whether a redirect is applied this cycle and its target.
  always_comb begin
    w_go      = 1'b0;
    w_go_addr = redirect_addr_i;
    w_latch   = 1'b0;
    case (r_state)
      c_st_run: begin
        w_go      = redirect_i && !w_blk;
        w_go_addr = redirect_addr_i;
        w_latch   = redirect_i && w_blk;
      end
      c_st_pend: begin
        // New redirects are ignored here; the parked one is older.
        w_go      = !w_blk;
        w_go_addr = r_pend_addr;
      end
      default: begin
        w_go      = 1'b0;
        w_go_addr = redirect_addr_i;
      end
    endcase
  end

  // Capture the target of a redirect that has to wait.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_pend_addr <= '0;
    end else if (w_latch) begin
      r_pend_addr <= redirect_addr_i;
    end
  end

  // ---------------------------------------------------------------------
  // Effective enables. An applied redirect overrides every stall below EXE
  // (none at or above EXE can exist when it is applied), so the front of
  // the pipe runs and is flushed instead.
  // ---------------------------------------------------------------------
  assign w_stall_eff = w_go ? '0            : w_hold;
  assign w_flush_eff = w_go ? w_redir_flush : w_bub;

  // Outputs are forced quiet while reset is asserted.
  assign stall_o  = rst_i ? '0 : w_stall_eff;
  assign flush_o  = rst_i ? '0 : w_flush_eff;
  assign pc_we_o  = !rst_i && w_go;
  assign new_pc_o = (!rst_i && w_go) ? w_go_addr : '0;

  // Watchdog: count consecutive stalled cycles, flag sticky at STALL_MAX.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_run     <= '0;
      r_timeout <= 1'b0;
    end else if (|w_stall_eff) begin
      if (r_run != c_run_max) begin
        r_run <= r_run + c_run_one;
      end
      if (r_run >= c_run_last) begin
        r_timeout <= 1'b1;
      end
    end else begin
      r_run <= '0;
    end
  end

  assign stall_timeout_o = r_timeout;

`ifdef PIPE_CTRL_PERF_EN
  localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

  logic [CNT_WIDTH-1:0] r_cycle_cnt;
  logic [CNT_WIDTH-1:0] r_stall_cnt;
  logic [CNT_WIDTH-1:0] r_flush_cnt;

  // Free-running performance counters, wrapping naturally.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cycle_cnt <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_cycle_cnt <= r_cycle_cnt + c_cnt_one;
      if (|w_stall_eff) r_stall_cnt <= r_stall_cnt + c_cnt_one;
      if (|w_flush_eff) r_flush_cnt <= r_flush_cnt + c_cnt_one;
    end
  end

  assign cycle_cnt_o = r_cycle_cnt;
  assign stall_cnt_o = r_stall_cnt;
  assign flush_cnt_o = r_flush_cnt;
`else
  assign cycle_cnt_o = '0;
  assign stall_cnt_o = '0;
  assign flush_cnt_o = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_ctrl
// Purpose  : Self-checking bench for pipe_ctrl: directed scenarios followed
//            by random traffic, compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_ctrl;

  localparam int N    = 5;
  localparam int EXE  = 2;
  localparam int SMAX = 64;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [N-1:0]    stall_req_i;
  logic            ld_exe_i;
  logic            exe_reg_we_i;
  logic [4:0]      exe_reg_waddr_i;
  logic            id_re1_i;
  logic            id_re2_i;
  logic [4:0]      id_raddr1_i;
  logic [4:0]      id_raddr2_i;
  logic            redirect_i;
  logic [31:0]     redirect_addr_i;
  logic [N-1:0]    stall_o;
  logic [N-1:0]    flush_o;
  logic            pc_we_o;
  logic [31:0]     new_pc_o;
  logic            stall_timeout_o;
  logic [31:0]     cycle_cnt_o;
  logic [31:0]     stall_cnt_o;
  logic [31:0]     flush_cnt_o;

  pipe_ctrl #(
    .NSTAGE(N), .EXE_IDX(EXE), .AW(32), .RAW(5), .STALL_MAX(SMAX), .CNT_WIDTH(32)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i), .stall_req_i(stall_req_i),
    .ld_exe_i(ld_exe_i), .exe_reg_we_i(exe_reg_we_i), .exe_reg_waddr_i(exe_reg_waddr_i),
    .id_re1_i(id_re1_i), .id_re2_i(id_re2_i),
    .id_raddr1_i(id_raddr1_i), .id_raddr2_i(id_raddr2_i),
    .redirect_i(redirect_i), .redirect_addr_i(redirect_addr_i),
    .stall_o(stall_o), .flush_o(flush_o), .pc_we_o(pc_we_o), .new_pc_o(new_pc_o),
    .stall_timeout_o(stall_timeout_o),
    .cycle_cnt_o(cycle_cnt_o), .stall_cnt_o(stall_cnt_o), .flush_cnt_o(flush_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  int total = 0;
  int bad   = 0;

  // Reference model state
  bit          m_pend;
  logic [31:0] m_pend_addr;
  int          m_run;
  bit          m_to;
  logic [31:0] m_cyc, m_stc, m_flc;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pend = 0; m_pend_addr = '0; m_run = 0; m_to = 0;
    m_cyc = '0; m_stc = '0; m_flc = '0;
  endtask

  task automatic chk_regs();
    chk("timeout", stall_timeout_o, m_to);
`ifdef PIPE_CTRL_PERF_EN
    chk("cycle_cnt", cycle_cnt_o, m_cyc);
    chk("stall_cnt", stall_cnt_o, m_stc);
    chk("flush_cnt", flush_cnt_o, m_flc);
`else
    chk("cycle_cnt", cycle_cnt_o, 0);
    chk("stall_cnt", stall_cnt_o, 0);
    chk("flush_cnt", flush_cnt_o, 0);
`endif
  endtask

  task automatic idle_in();
    stall_req_i = '0; ld_exe_i = 0; exe_reg_we_i = 0; exe_reg_waddr_i = '0;
    id_re1_i = 0; id_re2_i = 0; id_raddr1_i = '0; id_raddr2_i = '0;
    redirect_i = 0; redirect_addr_i = '0;
  endtask

  // One clock cycle: called just after an edge; checks combinational outputs
  // mid-cycle, then advances the model across the next rising edge.
  task automatic cyc();
    bit lu, blk, go;
    int s;
    logic [31:0] addr;
    logic [N-1:0] es, ef;
    logic ep;
    logic [31:0] enp;
    #2;
    lu = ld_exe_i && exe_reg_we_i && (exe_reg_waddr_i != 0) &&
         ((id_re1_i && id_raddr1_i == exe_reg_waddr_i) ||
          (id_re2_i && id_raddr2_i == exe_reg_waddr_i));
    s = -1;
    for (int k = 0; k < N; k++) if (stall_req_i[k]) s = k;
    if (lu && s < 1) s = 1;
    blk  = (s >= EXE);
    go   = m_pend ? !blk : (redirect_i && !blk);
    addr = m_pend ? m_pend_addr : redirect_addr_i;
    if (go) begin
      es = '0; ef = N'(((1 << (EXE + 1)) - 1) & ~1); ep = 1; enp = addr;
    end else begin
      es  = (s < 0) ? '0 : N'((1 << (s + 1)) - 1);
      ef  = (s >= 0 && s + 1 < N) ? N'(1 << (s + 1)) : '0;
      ep  = 0; enp = '0;
    end
    chk("stall", stall_o, es);
    chk("flush", flush_o, ef);
    chk("pc_we", pc_we_o, ep);
    chk("new_pc", new_pc_o, enp);
    chk_regs();
    @(posedge clk_i);
    #1;
    if (!m_pend && redirect_i && blk) begin
      m_pend = 1; m_pend_addr = redirect_addr_i;
    end else if (m_pend && !blk) begin
      m_pend = 0;
    end
    if (es != 0) begin
      m_run++;
      if (m_run >= SMAX) m_to = 1;
    end else begin
      m_run = 0;
    end
    m_cyc++;
    if (es != 0) m_stc++;
    if (ef != 0) m_flc++;
  endtask

  // Asynchronous reset pulse between edges; outputs must go quiet at once.
  task automatic rst_pulse();
    #1 rst_i = 1;
    #2;
    model_reset();
    chk("rst_stall", stall_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_pc_we", pc_we_o, 0);
    chk("rst_new_pc", new_pc_o, 0);
    chk_regs();
    #1 rst_i = 0;
  endtask

  initial begin
    idle_in();
    model_reset();
    rst_i = 1;
    @(posedge clk_i);
    #1;
    chk("rst_stall", stall_o, 0);
    chk("rst_flush", flush_o, 0);
    chk("rst_pc_we", pc_we_o, 0);
    chk_regs();
    rst_i = 0;

    // Idle after reset
    repeat (10) cyc();
`ifdef PIPE_CTRL_PERF_EN
    #2 chk("idle10_cycles", cycle_cnt_o, 10);
    @(posedge clk_i); #1; m_cyc++;
`endif

    // Load-use on source 1, then the same with destination x0
    ld_exe_i = 1; exe_reg_we_i = 1; exe_reg_waddr_i = 5; id_re1_i = 1; id_raddr1_i = 5;
    cyc();
    exe_reg_waddr_i = 0; id_raddr1_i = 0;
    cyc();
    // Load-use on source 2 only
    exe_reg_waddr_i = 7; id_re1_i = 0; id_re2_i = 1; id_raddr2_i = 7;
    cyc();
    // Not a load -> no hazard
    ld_exe_i = 0;
    cyc();
    idle_in();

    // Redirect with no stall, then with a load-use hazard active
    redirect_i = 1; redirect_addr_i = 32'h100;
    cyc();
    ld_exe_i = 1; exe_reg_we_i = 1; exe_reg_waddr_i = 5; id_re1_i = 1; id_raddr1_i = 5;
    cyc();
    idle_in();

    // Redirect blocked by stall at index 3 for 3 cycles
    stall_req_i = 5'b01000; redirect_i = 1; redirect_addr_i = 32'h200;
    cyc();
    redirect_i = 1; redirect_addr_i = 32'h300;   // ignored while pending
    cyc();
    redirect_i = 0;
    cyc();
    stall_req_i = '0;
    cyc();
    cyc();

    // LU together with a stall at index 3: the deeper stall wins
    stall_req_i = 5'b01000;
    ld_exe_i = 1; exe_reg_we_i = 1; exe_reg_waddr_i = 9; id_re1_i = 1; id_raddr1_i = 9;
    cyc();
    idle_in();
    // Last register stalled: everything holds, no bubble
    stall_req_i = 5'b10000;
    cyc();
    // Stall at index 1 plus redirect: redirect overrides
    stall_req_i = 5'b00010; redirect_i = 1; redirect_addr_i = 32'h440;
    cyc();
    idle_in();
    cyc();

    // Watchdog: stall at index 2 held beyond STALL_MAX cycles
    stall_req_i = 5'b00100;
    repeat (SMAX + 2) cyc();
    stall_req_i = '0;
    repeat (3) cyc();

    // Park a redirect, then reset in the middle of PEND
    stall_req_i = 5'b01000; redirect_i = 1; redirect_addr_i = 32'h500;
    cyc();
    redirect_i = 0;
    rst_pulse();
    stall_req_i = '0;
    cyc();
    cyc();

    // Random traffic
    for (int i = 0; i < 500; i++) begin
      for (int k = 0; k < N; k++) stall_req_i[k] = ($urandom_range(0, 7) == 0);
      ld_exe_i        = $urandom_range(0, 1);
      exe_reg_we_i    = $urandom_range(0, 3) != 0;
      exe_reg_waddr_i = 5'($urandom_range(0, 3));
      id_re1_i        = $urandom_range(0, 1);
      id_re2_i        = $urandom_range(0, 1);
      id_raddr1_i     = 5'($urandom_range(0, 3));
      id_raddr2_i     = 5'($urandom_range(0, 3));
      redirect_i      = ($urandom_range(0, 3) == 0);
      redirect_addr_i = $urandom;
      if ($urandom_range(0, 149) == 0) rst_pulse();
      cyc();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_ctrl.md
# pipe_ctrl

Parametrised pipeline control unit for the in-order core: arbitrates per-stage stall requests, load-use hazards and EXE-stage branch redirects, and drives a hold (stall) and bubble (flush) enable into every pipeline register plus the PC write port. It sits beside the pc_reg / if_id / id_exe / exe_mem / mem_wb chain and generalises the fixed 5-stage, no-stall pipeline to NSTAGE stages with stalls, redirects, a stall watchdog and optional performance counters.

## Interface
- NSTAGE, 5, number of pipeline registers; index 0 = PC, 1 = IF/ID, 2 = ID/EXE, 3 = EXE/MEM, 4 = MEM/WB
- EXE_IDX, 2, index of the register feeding EXE; 1 < EXE_IDX < NSTAGE
- AW, 32, instruction address width
- RAW, 5, register address width
- STALL_MAX, 64, consecutive stalled cycles before the watchdog fires (≥ 2)
- CNT_WIDTH, 32, performance counter width
- clk_i  in  1  clock; all state updates on the rising edge
- rst_i  in  1  reset, asynchronous, active-high
- stall_req_i  in  NSTAGE  bit k: stage k cannot accept/produce this cycle
- ld_exe_i  in  1  instruction in EXE is a load
- exe_reg_we_i  in  1  EXE instruction writes a register
- exe_reg_waddr_i  in  RAW  EXE destination register
- id_re1_i, id_re2_i  in  1  ID reads source 1 / 2
- id_raddr1_i, id_raddr2_i  in  RAW  ID source addresses
- redirect_i  in  1  branch/jump in EXE is taken
- redirect_addr_i  in  AW  target address
- stall_o  out  NSTAGE  bit k: register k holds its value
- flush_o  out  NSTAGE  bit k: register k loads a bubble (we=0, nop)
- pc_we_o  out  1  PC loads new_pc_o instead of its increment
- new_pc_o  out  AW  redirect target
- stall_timeout_o  out  1  sticky watchdog flag
- cycle_cnt_o, stall_cnt_o, flush_cnt_o  out  CNT_WIDTH  performance counters

## Operation
- Load-use hazard LU = ld_exe_i & exe_reg_we_i & exe_reg_waddr_i≠0 & ((id_re1_i & id_raddr1_i==exe_reg_waddr_i) | (id_re2_i & id_raddr2_i==exe_reg_waddr_i)); treated as a stall request at index 1.
- Effective stall index s = highest k with stall_req_i[k] (or 1 if LU). stall_o[j]=1 for all j≤s; flush_o[s+1]=1 if s+1<NSTAGE.
- Redirect applicable when no stall index ≥ EXE_IDX: pc_we_o=1, new_pc_o=target, flush_o[1..EXE_IDX]=1, stall_o[0..EXE_IDX]=0; overrides LU and any stall with index <EXE_IDX.
- FSM states RUN, PEND:
  - RUN: redirect_i while a stall index ≥ EXE_IDX exists → latch redirect_addr_i into pend_addr, go PEND; no PC write.
  - PEND: redirect_i ignored; when no stall index ≥ EXE_IDX, apply the redirect using pend_addr (same outputs as above), return to RUN that edge.
- Watchdog: run counter increments each cycle with any stall_o bit set, clears on a stall-free cycle; reaching STALL_MAX sets stall_timeout_o, cleared only by reset.
- With no stall and no redirect, all stall_o, flush_o and pc_we_o are 0.

## Timing
- stall_o, flush_o, pc_we_o and new_pc_o are combinational from inputs and state, valid in the same cycle; the pipeline registers act on the next edge.
- Redirect latency zero in RUN; in PEND, applied in the first cycle the blocking stall drops.
- Reset (asynchronous, any time, including mid-PEND): state RUN, pend_addr 0, run counter 0, stall_timeout_o 0, all counters 0; while rst_i high stall_o=0, flush_o=0, pc_we_o=0, new_pc_o=0.
- Simultaneous LU and stall_req_i[k], k>1: stall index k wins, flush_o[k+1] only.
- stall_req_i[NSTAGE-1]: every register holds, no flush.

## Configuration
- PIPE_CTRL_PERF_EN defined: cycle_cnt_o +1 every cycle out of reset; stall_cnt_o +1 on any stall_o bit; flush_cnt_o +1 on any flush_o bit; all wrap modulo 2^CNT_WIDTH.
- Not defined: counters not instantiated, the three outputs tied to 0.

## Test plan
- Reset then idle 10 cycles, no requests -> stall_o=0, flush_o=0, pc_we_o=0; with PIPE_CTRL_PERF_EN, cycle_cnt_o=10.
- ld_exe_i=1, exe_reg_waddr_i=5, id_re1_i=1, id_raddr1_i=5 -> stall_o=5'b00011, flush_o=5'b00100; same with waddr 0 -> no stall.
- redirect_i=1, target 0x100, no stalls -> pc_we_o=1, new_pc_o=0x100, flush_o=5'b00110, also while LU is active.
- stall_req_i[3] 3 cycles plus redirect_i to 0x200 on the first -> stall_o=5'b01111, flush_o=5'b10000, pc_we_o=0 for 3 cycles; 4th cycle pc_we_o=1, new_pc_o=0x200, then RUN.
- stall_req_i[2] held STALL_MAX cycles -> stall_timeout_o rises after cycle 64 and stays 1 after request drops; rst_i pulse mid-PEND clears it and the pending redirect.
